// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: FSM encoding and
// requester count.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Rotating-priority search over four requesters: scans base+1 .. base+4
// (mod 4) and reports the first requester found.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       base,
  input  logic             mask_en,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = base + 2'(i);
      // The last candidate wraps back onto base; masking it skips the owner.
      if (!found && req[cand] && !(mask_en && (i == N_REQ))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 data path with a bounded hold time
// per owner and a registered one-hot grant.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] din,
  output logic [N_REQ-1:0]   gnt,
  output logic [1:0]         sel,
  output logic               valid,
  output logic [W-1:0]       dout
);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       pick_base;
  logic             pick_mask;

  // While granted, ptr equals owner, so one search serves both the idle
  // winner lookup and the "others" lookup that excludes the owner.
  assign pick_base = (state_q == GRANT) ? owner_q : ptr_q;
  assign pick_mask = (state_q == GRANT);

  rr_pick4 u_pick (
    .req     (req),
    .base    (pick_base),
    .mask_en (pick_mask),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          valid_d = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (!req[owner_q] || (cnt_q >= 4'(HOLD_MAX))) begin
          if (pick_found) begin
            owner_d = pick_idx;
            ptr_d   = pick_idx;
            gnt_d   = N_REQ'(1) << pick_idx;
            valid_d = 1'b1;
            cnt_d   = 4'd1;
          end else if (!req[owner_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = 4'd0;
          end
          // Owner still requesting with nobody waiting: cnt stays saturated.
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= 4'd0;
      owner_q <= 2'd0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = owner_q;
  assign valid = valid_q;

  always_comb begin
    dout = '0;
    if (valid_q) dout = din[owner_q*W +: W];
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomized checks of rr_mux_arbiter against a behavioural
// round-robin model.
module tb_rr_mux_arbiter;

  localparam int W        = 4;
  localparam int HOLD_MAX = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [3:0]     req = 4'd0;
  logic [4*W-1:0] din = '0;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           valid;
  logic [W-1:0]   dout;

  int checks = 0;
  int errors = 0;

  // Model state: owner index (-1 when nothing is granted), cycles held,
  // last winner and the select value currently presented.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 3;
  int m_sel   = 0;

  rr_mux_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // First requester found going round the ring after 'from'; optionally skip 'from' itself.
  function automatic int first_after(int from, logic [3:0] r, bit skip_self);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (from + i) % 4;
      if (skip_self && k == from) continue;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      w = first_after(m_last, r, 1'b0);
      if (w >= 0) begin m_owner = w; m_held = 1; m_last = w; m_sel = w; end
    end else begin
      bit wants_more;
      bit budget_left;
      wants_more  = r[m_owner];
      budget_left = (m_held < HOLD_MAX);
      if (wants_more && budget_left) begin
        m_held++;
      end else begin
        w = first_after(m_owner, r, 1'b1);
        if (w >= 0) begin
          m_owner = w; m_held = 1; m_last = w; m_sel = w;
        end else if (!wants_more) begin
          m_owner = -1; m_held = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]   e_gnt;
    logic [W-1:0] e_dout;
    e_gnt  = (m_owner < 0) ? 4'd0 : (4'd1 << m_owner);
    e_dout = (m_owner < 0) ? '0 : din[m_owner*W +: W];
    checks++;
    assert (gnt === e_gnt) else begin
      errors++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
    end
    checks++;
    assert (valid === (m_owner >= 0)) else begin
      errors++; $error("FAIL %s valid observed=%b expected=%b", tag, valid, (m_owner >= 0));
    end
    checks++;
    assert (sel === 2'(m_sel)) else begin
      errors++; $error("FAIL %s sel observed=%0d expected=%0d", tag, sel, m_sel);
    end
    checks++;
    assert (dout === e_dout) else begin
      errors++; $error("FAIL %s dout observed=%h expected=%h", tag, dout, e_dout);
    end
    checks++;
    assert ($onehot0(gnt) && (!valid || gnt[sel])) else begin
      errors++; $error("FAIL %s gnt_sel_consistency observed gnt=%b sel=%0d valid=%b expected onehot gnt[sel]", tag, gnt, sel, valid);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs, input string tag);
    req = r;
    rst = rs;
    din = {$urandom, $urandom};
    @(posedge clk);
    model_edge(r, rs);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset state
    step(4'b1111, 1'b1, "reset");
    step(4'b0000, 1'b1, "reset_hold");

    // Single requester up and down
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, "single_req");
    step(4'b0000, 1'b0, "single_drop");
    step(4'b0000, 1'b0, "idle");

    // All requesting: rotation 0,1,2,3,0 with 4-cycle holds
    step(4'b0000, 1'b1, "reset2");
    for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, "all_req");

    // Lone requester saturates, no rotation
    step(4'b0000, 1'b1, "reset3");
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0, "lone_req");

    // Owner 3 drops while 0 waits: wrap-around handoff
    step(4'b0000, 1'b1, "reset4");
    step(4'b1000, 1'b0, "own3");
    step(4'b1001, 1'b0, "own3_hold");
    step(4'b0001, 1'b0, "wrap_handoff");
    step(4'b0001, 1'b0, "wrap_hold");

    // Reset mid-grant, then first grant after reset
    step(4'b0000, 1'b1, "reset5");
    step(4'b0100, 1'b0, "own2");
    step(4'b0100, 1'b0, "own2_cnt2");
    step(4'b1111, 1'b1, "rst_midgrant");
    step(4'b1100, 1'b0, "post_rst_grant");
    step(4'b1100, 1'b0, "post_rst_hold");

    // Randomized traffic with occasional resets
    step(4'b0000, 1'b1, "reset6");
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic       rs;
      r  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom) & 4'($urandom);
      rs = ($urandom_range(0, 49) == 0);
      step(r, rs, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter W, default 1, width of each requester data lane and of dout.
REQ-002 Parameter HOLD_MAX, default 4, maximum consecutive grant cycles while another requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  request lines; bit k = requester k wants the shared 4:1 path.
REQ-006 din  input  4*W  data lanes; lane k = din[k*W +: W].
REQ-007 gnt  output  4  one-hot registered grant; all-zero when idle.
REQ-008 sel  output  2  registered mux select, binary index of the granted requester.
REQ-009 valid  output  1  registered; 1 while any grant is held.
REQ-010 dout  output  W  combinational lane din[sel] when valid=1; all-zero when valid=0.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 Registers: 2-bit last-winner pointer ptr; 4-bit hold counter cnt; owner index (drives sel).
REQ-013 Winner search SHALL scan indices ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) and pick the first with req set; "others" search from owner+1 SHALL exclude the owner.
REQ-014 IDLE, req==0: stay IDLE; gnt=0, valid=0, sel holds its last value.
REQ-015 IDLE, req!=0: next edge go to GRANT, owner=winner, gnt=one-hot(winner), valid=1, cnt=1, ptr=winner (one-cycle req-to-gnt latency).
REQ-016 GRANT, req[owner]=0, other requests present: next edge switch directly to the next winner searched from owner+1; cnt=1; ptr updated; no idle bubble.
REQ-017 GRANT, req[owner]=0, no other request: next edge return to IDLE; gnt=0, valid=0.
REQ-018 GRANT, req[owner]=1, cnt<HOLD_MAX: keep owner, cnt increments by 1.
REQ-019 GRANT, req[owner]=1, cnt==HOLD_MAX, another request present: forced rotation to the next winner searched from owner+1; cnt=1.
REQ-020 GRANT, req[owner]=1, cnt==HOLD_MAX, no other request: keep owner; cnt saturates at HOLD_MAX.
REQ-021 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set gnt bit whenever valid=1.
REQ-022 Changes on req SHALL affect gnt/sel/valid only at the next rising edge; dout follows din combinationally with no added latency.
REQ-023 ptr wrap-around: after index 3 wins, index 0 has highest priority on the next search.

Reset
REQ-024 With rst=1 at a rising edge: state=IDLE, gnt=0000, sel=00, valid=0, cnt=0, ptr=3; dout=0 as a consequence of valid=0.
REQ-025 Reset SHALL take priority over every transition, including mid-grant and forced rotation; req sampled during that same edge SHALL be ignored.
REQ-026 After reset the first grant SHALL go to the lowest-index requester.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1) and the requester count constant N_REQ=4.
REQ-028 The rotating-priority search SHALL be a combinational sub-module rr_pick4, with inputs req[3:0], base[1:0] and mask_en, and outputs found and idx[1:0]; rr_mux_arbiter instantiates it.
REQ-029 The 4:1 data select SHALL be written inline in rr_mux_arbiter; no clocked logic outside rr_mux_arbiter.

Verification
REQ-030 Reset then req=0001 for 3 cycles, then 0000 -> one edge after req rises: gnt=0001, sel=00, valid=1; one edge after req=0000: gnt=0000, valid=0.
REQ-031 req=1111 held, HOLD_MAX=4 -> grant order 0,1,2,3,0, each owner held exactly 4 cycles; dout=din lane of current sel.
REQ-032 req=0100 alone held for 10 cycles -> gnt=0100 for all 10 cycles; cnt saturates at 4; no rotation.
REQ-033 Owner 3 drops req while req[0]=1 -> next edge gnt=0001, sel=00 with no idle cycle (wrap-around check).
REQ-034 rst=1 asserted while owner=2 with cnt=2 -> next edge gnt=0000, valid=0, sel=00; with req=1100 after rst drops, the first grant goes to 2.
REQ-035 Every cycle of every test: gnt is one-hot or zero, gnt matches sel when valid=1, and dout=0 when valid=0.
